// File: rtl/tff_counter_ctrl.sv
// Toggle-vector sequencer driving a WIDTH-bit T-FF bank as an up/down modulus counter.
// Optional prescaler enabled by defining TFF_CTRL_PRESCALE_EN.
module tff_counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] mod_r;
  logic             one_r;
  logic             busy_r;
  logic             tc_r;
  logic [WIDTH-1:0] t_s;
  logic             tc_nxt_s;
  logic             tick_s;
  logic             term_s;

  // Toggle mask for +1: bit i toggles when all lower bits are one.
  function automatic logic [WIDTH-1:0] up_mask(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    logic             c;
    c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = c;
      c    = c & v[i];
    end
    return m;
  endfunction

  // Toggle mask for -1: bit i toggles when all lower bits are zero.
  function automatic logic [WIDTH-1:0] dn_mask(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    logic             c;
    c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = c;
      c    = c & ~v[i];
    end
    return m;
  endfunction

`ifdef TFF_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_r;

  assign tick_s = (state_r == RUN) && (pre_r == PW'(PRESCALE - 1));

  // Prescale counter: held at zero outside RUN and on the cycle leaving RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_r <= {PW{1'b0}};
    end else if ((state_r != RUN) || (state_nxt_s != RUN)) begin
      pre_r <= {PW{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PW{1'b0}};
    end else begin
      pre_r <= pre_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign tick_s = (state_r == RUN) && (PRESCALE >= 32'sd1);
`endif

  assign term_s = up_dn ? (q_r == mod_r) : (q_r == {WIDTH{1'b0}});

  // Next-state, toggle vector and terminal-count decision; load owns q, stop/start own state.
  always_comb begin
    t_s         = {WIDTH{1'b0}};
    state_nxt_s = state_r;
    tc_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
        if (load) begin
          t_s = q_r ^ load_val;
        end else begin
          t_s = {WIDTH{1'b0}};
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
        if (load) begin
          t_s = q_r ^ load_val;
        end else if (stop || !tick_s) begin
          t_s = {WIDTH{1'b0}};
        end else if (term_s) begin
          tc_nxt_s = 1'b1;
          if (one_r) begin
            state_nxt_s = IDLE;
            t_s         = {WIDTH{1'b0}};
          end else if (up_dn) begin
            t_s = q_r;
          end else begin
            t_s = q_r ^ mod_r;
          end
        end else if (up_dn) begin
          t_s = up_mask(q_r);
        end else begin
          t_s = dn_mask(q_r);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        t_s         = {WIDTH{1'b0}};
        tc_nxt_s    = 1'b0;
      end
    endcase
  end

  // T-FF bank, state and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      q_r     <= {WIDTH{1'b0}};
      mod_r   <= {WIDTH{1'b0}};
      one_r   <= 1'b0;
      busy_r  <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      q_r     <= q_r ^ t_s;
      busy_r  <= (state_nxt_s == RUN);
      tc_r    <= tc_nxt_s;
      if ((state_r == IDLE) && start) begin
        mod_r <= mod_val;
        one_r <= oneshot;
      end else begin
        mod_r <= mod_r;
        one_r <= one_r;
      end
    end
  end

  // t_vec is forced quiet while reset is held so an external bank stays put.
  assign t_vec = reset_n ? t_s : {WIDTH{1'b0}};
  assign q     = q_r;
  assign busy  = busy_r;
  assign tc    = tc_r;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_tff_counter_ctrl;
  localparam int W  = 4;
  localparam int PS = 3;

  logic         clk      = 1'b0;
  logic         reset_n  = 1'b0;
  logic         start    = 1'b0;
  logic         stop     = 1'b0;
  logic         up_dn    = 1'b1;
  logic         oneshot  = 1'b0;
  logic         load     = 1'b0;
  logic [W-1:0] mod_val  = 4'd0;
  logic [W-1:0] load_val = 4'd0;
  logic [W-1:0] t_vec;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;

  int total = 0;
  int bad   = 0;

  int m_q   = 0;
  int m_mod = 0;
  int m_pc  = 0;
  bit m_run = 1'b0;
  bit m_one = 1'b0;
  bit m_tc  = 1'b0;

  tff_counter_ctrl #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .up_dn(up_dn),
    .oneshot(oneshot), .mod_val(mod_val), .load(load), .load_val(load_val),
    .t_vec(t_vec), .q(q), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: counter value as an integer mod 16, next value from the counting rules.
  task automatic model_eval(output int nq, output bit nrun, output bit ntc, output int npc);
    bit tick;
    nq   = m_q;
    nrun = m_run;
    ntc  = 1'b0;
    npc  = 0;
`ifdef TFF_CTRL_PRESCALE_EN
    tick = m_run && (m_pc == PS - 1);
    if (m_run) npc = (m_pc + 1) % PS;
`else
    tick = m_run;
`endif
    if (!m_run) nrun = start;
    else if (stop) nrun = 1'b0;
    if (load) begin
      nq = int'(load_val);
    end else if (m_run && !stop && tick) begin
      if (up_dn) begin
        if (m_q == m_mod) begin
          ntc = 1'b1;
          if (m_one) nrun = 1'b0;
          else nq = 0;
        end else begin
          nq = (m_q + 1) % 16;
        end
      end else begin
        if (m_q == 0) begin
          ntc = 1'b1;
          if (m_one) nrun = 1'b0;
          else nq = m_mod;
        end else begin
          nq = m_q - 1;
        end
      end
    end
    if (!nrun || !m_run) npc = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    int  nq;
    bit  nrun;
    bit  ntc;
    int  npc;
    if (!reset_n) begin
      m_q   <= 0;
      m_mod <= 0;
      m_pc  <= 0;
      m_run <= 1'b0;
      m_one <= 1'b0;
      m_tc  <= 1'b0;
    end else begin
      model_eval(nq, nrun, ntc, npc);
      if (!m_run && start) begin
        m_mod <= int'(mod_val);
        m_one <= oneshot;
      end
      m_q   <= nq;
      m_run <= nrun;
      m_tc  <= ntc;
      m_pc  <= npc;
    end
  end

  always @(negedge clk) begin
    int  nq;
    bit  nrun;
    bit  ntc;
    int  npc;
    int  exp_t;
    model_eval(nq, nrun, ntc, npc);
    exp_t = reset_n ? ((nq ^ m_q) & 15) : 0;
    chk("cyc_t_vec", 32'(t_vec), 32'(exp_t));
    chk("cyc_q", 32'(q), 32'(m_q));
    chk("cyc_busy", 32'(busy), 32'(m_run));
    chk("cyc_tc", 32'(tc), 32'(m_tc));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_val = v;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tc", 32'(tc), 32'd0);
    load_val = 4'd5;
    load     = 1'b1;
    #1;
    chk("rst_t_vec_quiet", 32'(t_vec), 32'd0);
    load     = 1'b0;
    step(1);
    reset_n  = 1'b1;

`ifdef TFF_CTRL_PRESCALE_EN
    up_dn = 1'b1; oneshot = 1'b0; mod_val = 4'd15;
    pulse_start();
    chk("ps_q0", 32'(q), 32'd0);
    step(1); chk("ps_q1", 32'(q), 32'd0);
    step(1); chk("ps_q2", 32'(q), 32'd0);
    step(1); chk("ps_q3", 32'(q), 32'd1);
    step(3); chk("ps_q6", 32'(q), 32'd2);
    pulse_stop();
    chk("ps_busy", 32'(busy), 32'd0);
`else
    // modulus 10 up-count, wrapping
    mod_val = 4'd9; up_dn = 1'b1; oneshot = 1'b0;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_q_start", 32'(q), 32'd0);
    step(9);  chk("t1_q9", 32'(q), 32'd9);  chk("t1_tc_pre", 32'(tc), 32'd0);
    step(1);  chk("t1_wrap", 32'(q), 32'd0); chk("t1_tc", 32'(tc), 32'd1);
    step(1);  chk("t1_q1", 32'(q), 32'd1);  chk("t1_tc_drop", 32'(tc), 32'd0);
    step(9);  chk("t1_period", 32'(q), 32'd0); chk("t1_tc2", 32'(tc), 32'd1);

    // down count from loaded 3, wrapping to 5
    pulse_stop();
    chk("t2_idle", 32'(busy), 32'd0);
    do_load(4'd3);
    chk("t2_load", 32'(q), 32'd3);
    up_dn = 1'b0; mod_val = 4'd5;
    pulse_start();
    chk("t2_q3", 32'(q), 32'd3);
    step(3); chk("t2_q0", 32'(q), 32'd0);
    step(1); chk("t2_q5", 32'(q), 32'd5); chk("t2_tc", 32'(tc), 32'd1);
    step(1); chk("t2_q4", 32'(q), 32'd4); chk("t2_tc_drop", 32'(tc), 32'd0);

    // oneshot up to 3
    pulse_stop();
    do_load(4'd0);
    up_dn = 1'b1; oneshot = 1'b1; mod_val = 4'd3;
    pulse_start();
    step(3); chk("t3_q3", 32'(q), 32'd3); chk("t3_busy", 32'(busy), 32'd1);
    step(1); chk("t3_hold", 32'(q), 32'd3); chk("t3_busy_fall", 32'(busy), 32'd0);
    chk("t3_tc", 32'(tc), 32'd1);
    step(2); chk("t3_tc_drop", 32'(tc), 32'd0); chk("t3_t_vec", 32'(t_vec), 32'd0);
    chk("t3_q_after", 32'(q), 32'd3);

    // load together with stop while running
    oneshot = 1'b0; mod_val = 4'd15;
    pulse_start();
    step(3); chk("t4_q6", 32'(q), 32'd6);
    load_val = 4'd12; load = 1'b1; stop = 1'b1;
    step(1);
    load = 1'b0; stop = 1'b0;
    chk("t4_q12", 32'(q), 32'd12); chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_tc", 32'(tc), 32'd0);
    step(2); chk("t4_q_hold", 32'(q), 32'd12);

    // modulus zero: tc every tick, q stays 0
    do_load(4'd0);
    mod_val = 4'd0;
    pulse_start();
    step(1); chk("m0_q", 32'(q), 32'd0); chk("m0_tc", 32'(tc), 32'd1);
    step(1); chk("m0_tc2", 32'(tc), 32'd1);
    pulse_stop();

    // start above modulus: natural wrap without tc
    do_load(4'd14);
    mod_val = 4'd3;
    pulse_start();
    step(1); chk("nw_q15", 32'(q), 32'd15);
    step(1); chk("nw_q0", 32'(q), 32'd0); chk("nw_no_tc", 32'(tc), 32'd0);
    step(3); chk("nw_q3", 32'(q), 32'd3);
    step(1); chk("nw_wrap", 32'(q), 32'd0); chk("nw_tc", 32'(tc), 32'd1);

    // asynchronous reset mid-run
    step(1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_q", 32'(q), 32'd0); chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_tc", 32'(tc), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("t5_quiet_q", 32'(q), 32'd0); chk("t5_quiet_busy", 32'(busy), 32'd0);
    mod_val = 4'd9;
    pulse_start();
    step(2); chk("t5_restart", 32'(q), 32'd2);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
